// File: rtl/piece_dealer.sv
// piece_dealer: latches a 7-piece bag from a producer and deals it one piece
// per handshake, with a one-entry preview, back-to-back reload on the last
// piece, and a sticky error flag for bags that are not a permutation of 0..6.
module piece_dealer (
  input  logic        clk,
  input  logic        nreset,
  input  logic        bag_done,
  input  logic [20:0] bag,
  output logic        newbag,
  input  logic        piece_req,
  output logic        piece_valid,
  output logic [2:0]  piece,
  output logic [2:0]  next_piece,
  output logic [2:0]  pieces_left,
  output logic        bag_err
);

  typedef enum logic {
    WAIT = 1'b0,
    DEAL = 1'b1
  } state_t;

  localparam logic [2:0]  NONE     = 3'b111;
  localparam logic [2:0]  BAG_SIZE = 3'd7;
  localparam logic [20:0] EMPTY    = '1;

  state_t      state, state_nxt;
  logic [20:0] buffer, buffer_nxt;
  logic [2:0]  left, left_nxt;
  logic        newbag_nxt;
  logic        err_nxt;

  logic        qual_done;
  logic        xfer;
  logic        last;
  logic        load;
  logic [6:0]  seen;
  logic        bag_ok;

  // While a newbag pulse is in flight the producer still shows its old done,
  // so done only counts when no clear is pending.
  assign qual_done = bag_done && !newbag;
  assign xfer      = (state == DEAL) && piece_req;
  assign last      = (left == 3'd1);
  assign load      = qual_done && ((state == WAIT) || (xfer && last));

  // Permutation check: seven slots holding seven distinct codes 0..6 cover
  // every code exactly once, so a full "seen" mask is sufficient.
  always_comb begin
    seen = '0;
    for (int k = 0; k < 7; k++) begin
      if (bag[3*k +: 3] != NONE) seen[bag[3*k +: 3]] = 1'b1;
    end
    bag_ok = &seen;
  end

  // Next-state logic: shift on transfer, reload on a qualified done.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt  = state;
    buffer_nxt = buffer;
    left_nxt   = left;
    newbag_nxt = 1'b0;
    err_nxt    = bag_err;

    case (state)
      WAIT: begin
        if (load) state_nxt = DEAL;
      end
      DEAL: begin
        if (xfer) begin
          buffer_nxt = {NONE, buffer[20:3]};
          left_nxt   = left - 3'd1;
          if (last && !load) state_nxt = WAIT;
        end
      end
      default: state_nxt = WAIT;
    endcase

    // A load overrides the shift so the last transfer and the reload share
    // one edge and dealing continues without a bubble.
    if (load) begin
      buffer_nxt = bag;
      left_nxt   = BAG_SIZE;
      newbag_nxt = 1'b1;
      err_nxt    = bag_err || !bag_ok;
    end
  end

  // State register; reset discards held pieces and cuts any newbag pulse.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= WAIT;
      buffer  <= EMPTY;
      left    <= 3'd0;
      newbag  <= 1'b0;
      bag_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state   <= state_nxt;
      buffer  <= buffer_nxt;
      left    <= left_nxt;
      newbag  <= newbag_nxt;
      bag_err <= err_nxt;
    end
  end

  // Dealing outputs decoded from the state and the head of the buffer.
  always_comb begin
    piece_valid = (state == DEAL);
    pieces_left = left;
    piece       = (state == DEAL) ? buffer[2:0] : NONE;
    next_piece  = ((state == DEAL) && (left > 3'd1)) ? buffer[5:3] : NONE;
  end

endmodule

// File: tb/tb_piece_dealer.sv
// Self-checking bench for piece_dealer: a queue-based model of the held
// pieces is compared every cycle, plus literal spot checks at key points.
module tb_piece_dealer;

  logic        clk = 1'b0;
  logic        nreset;
  logic        bag_done;
  logic [20:0] bag;
  logic        newbag;
  logic        piece_req;
  logic        piece_valid;
  logic [2:0]  piece;
  logic [2:0]  next_piece;
  logic [2:0]  pieces_left;
  logic        bag_err;

  int tests = 0;
  int fails = 0;
  int nb_count = 0;

  piece_dealer dut (
    .clk         (clk),
    .nreset      (nreset),
    .bag_done    (bag_done),
    .bag         (bag),
    .newbag      (newbag),
    .piece_req   (piece_req),
    .piece_valid (piece_valid),
    .piece       (piece),
    .next_piece  (next_piece),
    .pieces_left (pieces_left),
    .bag_err     (bag_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: the held pieces as a queue, front = current piece.
  int q[$];
  bit m_newbag;
  bit m_err;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      q.delete();
      m_newbag = 1'b0;
      m_err    = 1'b0;
    end else begin
      bit qd, tx, ld;
      bit seen[7];
      qd = bag_done && !m_newbag;
      tx = (q.size() > 0) && piece_req;
      ld = qd && ((q.size() == 0) || (tx && q.size() == 1));
      if (tx) void'(q.pop_front());
      if (ld) begin
        q.delete();
        for (int k = 0; k < 7; k++) seen[k] = 1'b0;
        for (int k = 0; k < 7; k++) begin
          int code;
          code = int'(bag[3*k +: 3]);
          q.push_back(code);
          if (code < 7) seen[code] = 1'b1;
        end
        for (int k = 0; k < 7; k++) if (!seen[k]) m_err = 1'b1;
      end
      m_newbag = ld;
    end
  end

  // Compare the DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (nreset) begin
      check("valid", int'(piece_valid), (q.size() > 0) ? 1 : 0);
      check("piece", int'(piece), (q.size() > 0) ? q[0] : 7);
      check("next_piece", int'(next_piece), (q.size() > 1) ? q[1] : 7);
      check("pieces_left", int'(pieces_left), q.size());
      check("newbag", int'(newbag), int'(m_newbag));
      check("bag_err", int'(bag_err), int'(m_err));
    end
  end

  always @(negedge clk) if (newbag) nb_count++;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Slot 0 is the low field, so these bags deal in the listed right-to-left order.
  localparam logic [20:0] BAG_A   = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  localparam logic [20:0] BAG_B   = {3'd4, 3'd2, 3'd5, 3'd1, 3'd6, 3'd0, 3'd3};
  localparam logic [20:0] BAG_HOLE = {3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd5, 3'd6};
  localparam logic [20:0] BAG_DUP = {3'd6, 3'd5, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};

  initial begin
    bit found;
    nreset = 1'b0; bag_done = 1'b0; bag = '0; piece_req = 1'b0;
    #3;
    check("rst_valid", int'(piece_valid), 0);
    check("rst_piece", int'(piece), 7);
    check("rst_next", int'(next_piece), 7);
    check("rst_left", int'(pieces_left), 0);
    check("rst_newbag", int'(newbag), 0);
    check("rst_err", int'(bag_err), 0);
    cyc(2);
    nreset = 1'b1;
    cyc(3);
    check("idle_no_newbag", nb_count, 0);

    // Basic load, continuous request, done held through the newbag cycle.
    bag = BAG_A; bag_done = 1'b1; piece_req = 1'b1;
    @(negedge clk);
    check("load_piece", int'(piece), 6);
    check("load_next", int'(next_piece), 5);
    check("load_left", int'(pieces_left), 7);
    check("load_newbag", int'(newbag), 1);
    #1;
    @(negedge clk);
    check("stale_newbag", int'(newbag), 0);
    check("stale_piece", int'(piece), 5);
    check("stale_left", int'(pieces_left), 6);
    #1 bag_done = 1'b0;
    cyc(6);
    check("drain_valid", int'(piece_valid), 0);
    check("basic_pulses", nb_count, 1);

    // Back-pressure, then back-to-back reload with BAG_B waiting.
    bag = BAG_A; bag_done = 1'b1; piece_req = 1'b0;
    @(negedge clk);
    #1 bag = BAG_B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_piece", int'(piece), 6);
      check("bp_next", int'(next_piece), 5);
      check("bp_left", int'(pieces_left), 7);
    end
    check("bp_pulses", nb_count, 2);
    #1 piece_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (newbag) found = 1'b1;
    end
    check("b2b_reload_seen", int'(found), 1);
    check("b2b_piece", int'(piece), 3);
    check("b2b_left", int'(pieces_left), 7);
    check("b2b_valid", int'(piece_valid), 1);
    #1;
    @(negedge clk);
    #1 bag_done = 1'b0;
    check("b2b_pulses", nb_count, 3);
    cyc(7);
    check("b2b_drain", int'(piece_valid), 0);

    // Bag with a 3'b111 slot: error sets, all seven slots still dealt.
    bag = BAG_HOLE; bag_done = 1'b1;
    @(negedge clk);
    check("hole_err", int'(bag_err), 1);
    #1 bag_done = 1'b0;
    cyc(8);
    check("hole_err_sticky", int'(bag_err), 1);
    nreset = 1'b0;
    #1 check("hole_err_cleared", int'(bag_err), 0);
    cyc(1);
    nreset = 1'b1;
    cyc(1);

    // Duplicate code 2, then reset after three transfers.
    bag = BAG_DUP; bag_done = 1'b1; piece_req = 1'b1;
    @(negedge clk);
    check("dup_err", int'(bag_err), 1);
    check("dup_piece", int'(piece), 0);
    #1 bag_done = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_left", int'(pieces_left), 4);
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_valid", int'(piece_valid), 0);
    check("mid_rst_left", int'(pieces_left), 0);
    check("mid_rst_err", int'(bag_err), 0);
    check("mid_rst_piece", int'(piece), 7);
    cyc(2);
    nreset = 1'b1;
    cyc(5);
    check("post_rst_idle", int'(piece_valid), 0);
    check("post_rst_pulses", nb_count, 5);

    // Reset during the newbag cycle cuts the pulse at once.
    bag = BAG_B; bag_done = 1'b1;
    @(posedge clk);
    #2;
    check("inflight_newbag", int'(newbag), 1);
    nreset = 1'b0;
    #1 check("inflight_cut", int'(newbag), 0);
    bag_done = 1'b0;
    cyc(2);
    nreset = 1'b1;
    cyc(3);
    check("final_pulses", nb_count, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
